// File: rtl/hold_start_seq.sv
// Hold-then-start sequencer: raises hold_o on a trigger, waits a programmable
// delay, emits one start_o pulse, then drops hold for at least one cycle.
module hold_start_seq #(
  parameter int unsigned DELAY_W   = 5,
  parameter int unsigned MAX_DELAY = 18,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic               abort_i,
  input  logic               clr_i,
  output logic               hold_o,
  output logic               start_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               aborted_o,
  output logic               err_o,
  output logic               ovr_o,
  output logic [CNT_W-1:0]   pulse_cnt_o
);

  localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIRE = 2'd2,
    S_COOL = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [DELAY_W-1:0] cnt, cnt_n;
  logic               hold, hold_n;
  logic               start, start_n;
  logic               busy, busy_n;
  logic               done, done_n;
  logic               aborted, aborted_n;
  logic               err, err_n;
  logic               ovr, ovr_n;
  logic [CNT_W-1:0]   pulse_cnt, pulse_cnt_n;
  logic               fire_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hold      <= 1'b0;
      start     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      err       <= 1'b0;
      ovr       <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hold      <= hold_n;
      start     <= start_n;
      busy      <= busy_n;
      done      <= done_n;
      aborted   <= aborted_n;
      err       <= err_n;
      ovr       <= ovr_n;
      pulse_cnt <= pulse_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hold_n    = hold;
    start_n   = 1'b0;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    err_n     = 1'b0;
    fire_inc  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (trig_i) begin
          if (delay_i > MAX_D) begin
            err_n = 1'b1;
          end else begin
            hold_n  = 1'b1;
            cnt_n   = delay_i;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // abort takes priority over an expiring count
        if (abort_i) begin
          hold_n    = 1'b0;
          done_n    = 1'b1;
          aborted_n = 1'b1;
          state_n   = S_COOL;
        end else if (cnt == '0) begin
          start_n = 1'b1;
          state_n = S_FIRE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_FIRE: begin
        hold_n   = 1'b0;
        done_n   = 1'b1;
        fire_inc = 1'b1;
        state_n  = S_COOL;
      end
      S_COOL: begin
        hold_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: begin
        hold_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);

    // a new overrun in the same cycle as a clear keeps the flag set
    ovr_n = (ovr & ~clr_i) | (trig_i & (state != S_IDLE));

    if (clr_i)
      pulse_cnt_n = '0;
    else if (fire_inc && (pulse_cnt != '1))
      pulse_cnt_n = pulse_cnt + 1'b1;
    else
      pulse_cnt_n = pulse_cnt;
  end

  assign hold_o      = hold;
  assign start_o     = start;
  assign busy_o      = busy;
  assign done_o      = done;
  assign aborted_o   = aborted;
  assign err_o       = err;
  assign ovr_o       = ovr;
  assign pulse_cnt_o = pulse_cnt;

endmodule

// File: tb/tb_hold_start_seq.sv
// Scoreboard bench for hold_start_seq: stimulus pushes expected start/done/err
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_hold_start_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trig;
  logic [4:0] delay;
  logic       abort;
  logic       clr;
  logic       hold, start, busy, done, aborted, err, ovr;
  logic [7:0] pulse_cnt;

  hold_start_seq #(.DELAY_W(5), .MAX_DELAY(18), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig_i      (trig),
    .delay_i     (delay),
    .abort_i     (abort),
    .clr_i       (clr),
    .hold_o      (hold),
    .start_o     (start),
    .busy_o      (busy),
    .done_o      (done),
    .aborted_o   (aborted),
    .err_o       (err),
    .ovr_o       (ovr),
    .pulse_cnt_o (pulse_cnt)
  );

  always #5 clk = ~clk;

  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic       ab;
    logic [7:0] cnt;
    int         hrise;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_hold = 1'b0, prev_start = 1'b0;
  int   hrise = -1;

  task automatic check_event(input int kind);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.cyc != cyc) begin
      errors++;
      $display("FAIL event_order: got kind %0d cycle %0d expected kind %0d cycle %0d",
               kind, cyc, e.kind, e.cyc);
    end
    checks++;
    case (kind)
      K_START: if (!hold || hrise != e.hrise) begin
        errors++;
        $display("FAIL start_hold: hold %0b rise %0d expected hold 1 rise %0d", hold, hrise, e.hrise);
      end
      K_DONE: if (aborted !== e.ab || pulse_cnt !== e.cnt || hold || start) begin
        errors++;
        $display("FAIL done_fields: aborted %0b cnt %0d hold %0b start %0b expected aborted %0b cnt %0d hold 0 start 0",
                 aborted, pulse_cnt, hold, start, e.ab, e.cnt);
      end
      default: if (hold || busy) begin
        errors++;
        $display("FAIL err_state: hold %0b busy %0b expected 0 0", hold, busy);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold  = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (hold && !prev_hold) hrise = cyc;
      if (start) begin
        checks++;
        if (prev_start) begin
          errors++;
          $display("FAIL start_width: start high two cycles in a row at cycle %0d", cyc);
        end
      end
      if (aborted && !done) begin
        errors++;
        $display("FAIL aborted_qual: aborted 1 without done at cycle %0d", cyc);
      end
      if (err) check_event(K_ERR);
      if (start && !prev_start) check_event(K_START);
      if (done) check_event(K_DONE);
      prev_hold  = hold;
      prev_start = start;
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_seq(input int d);
    int   k;
    exp_t e;
    @(negedge clk);
    trig  = 1'b1;
    delay = 5'(d);
    k     = cyc + 1;
    if (d > 18) begin
      e = '{K_ERR, k, 1'b0, 8'd0, 0};
      q.push_back(e);
    end else begin
      e = '{K_START, k + 1 + d, 1'b0, 8'd0, k};
      q.push_back(e);
      exp_cnt = sat_inc(exp_cnt);
      e = '{K_DONE, k + 2 + d, 1'b0, exp_cnt, 0};
      q.push_back(e);
    end
    @(negedge clk);
    trig = 1'b0;
    repeat (d + 4) @(negedge clk);
  endtask

  task automatic seq_abort(input int d, input int after);
    int   k;
    exp_t e;
    @(negedge clk);
    trig  = 1'b1;
    delay = 5'(d);
    k     = cyc + 1;
    e = '{K_DONE, k + after, 1'b1, exp_cnt, 0};
    q.push_back(e);
    @(negedge clk);
    trig = 1'b0;
    while (cyc < k + after - 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (d + 4) @(negedge clk);
  endtask

  initial begin
    int         k;
    int         k0;
    exp_t       e;
    logic [7:0] c;
    rst_n = 1'b0;
    trig  = 1'b0;
    delay = 5'd0;
    abort = 1'b0;
    clr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {24'd0, hold, start, busy, done, aborted, err, ovr, 1'b0}, 32'd0);
    chk("reset_cnt", {24'd0, pulse_cnt}, 32'd0);
    rst_n = 1'b1;

    run_seq(0);
    run_seq(7);
    seq_abort(5, 2);
    chk("cnt_after_abort", {24'd0, pulse_cnt}, {24'd0, exp_cnt});
    run_seq(19);
    chk("busy_after_err", {31'd0, busy}, 32'd0);
    seq_abort(0, 1);

    // clear coinciding with the FIRE increment
    @(negedge clk);
    trig  = 1'b1;
    delay = 5'd1;
    k     = cyc + 1;
    e = '{K_START, k + 2, 1'b0, 8'd0, k};
    q.push_back(e);
    e = '{K_DONE, k + 3, 1'b0, 8'd0, 0};
    q.push_back(e);
    exp_cnt = 8'd0;
    @(negedge clk);
    trig = 1'b0;
    while (cyc < k + 2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovr_idle", {31'd0, ovr}, 32'd0);

    // trigger held high: back-to-back sequences every 6 cycles
    @(negedge clk);
    trig  = 1'b1;
    delay = 5'd2;
    k0    = cyc + 1;
    c     = exp_cnt;
    for (int n = 0; n < 300; n++) begin
      e = '{K_START, k0 + 6 * n + 3, 1'b0, 8'd0, k0 + 6 * n};
      q.push_back(e);
      c = sat_inc(c);
      e = '{K_DONE, k0 + 6 * n + 4, 1'b0, c, 0};
      q.push_back(e);
    end
    exp_cnt = c;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_set", {31'd0, ovr}, 32'd1);
    while (cyc < k0 + 6 * 299) @(negedge clk);
    trig = 1'b0;
    repeat (8) @(negedge clk);
    chk("cnt_saturated", {24'd0, pulse_cnt}, 32'd255);

    // clear with no overrun pending
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_cnt = 8'd0;
    chk("ovr_cleared", {31'd0, ovr}, 32'd0);
    chk("cnt_cleared", {24'd0, pulse_cnt}, 32'd0);

    // reset while in WAIT
    @(negedge clk);
    trig  = 1'b1;
    delay = 5'd10;
    @(negedge clk);
    trig = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_before_reset", {31'd0, hold}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_hold_start", {30'd0, hold, start}, 32'd0);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("hold_after_reset", {31'd0, hold}, 32'd0);

    run_seq(3);

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected events never seen", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
